// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, FSM encoding and reset constants shared by the CLINT timer.
package clint_pkg;
    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;
    localparam logic [63:0] MTIMECMP_RST      = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} clint_state_t;

    // One-hot select {mtime_hi, mtime_lo, mtimecmp_hi, mtimecmp_lo, msip}; zero when unmapped.
    function automatic logic [4:0] clint_decode(input logic [13:0] word);
        return {word == CLINT_MTIME_HI[15:2], word == CLINT_MTIME_LO[15:2],
                word == CLINT_MTIMECMP_HI[15:2], word == CLINT_MTIMECMP_LO[15:2],
                word == CLINT_MSIP[15:2]};
    endfunction
endpackage

// File: rtl/clint_mtime_counter.sv
// clint_mtime_counter: prescaled 64-bit mtime with half-word write ports that override the tick.
module clint_mtime_counter #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] mtime
);
    logic [31:0] psc;
    logic        tick;

    assign tick = psc == 32'(TICK_DIV - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            psc   <= '0;
            mtime <= '0;
        end else begin
            psc <= tick ? '0 : psc + 32'd1;
            if (wr_lo || wr_hi)
                mtime <= {wr_hi ? wdata : mtime[63:32], wr_lo ? wdata : mtime[31:0]};
            else if (tick)
                mtime <= mtime + 64'd1;
        end
    end
endmodule

// File: rtl/clint_timer.sv
// clint_timer: bus-mapped msip/mtimecmp/mtime block driving the core's mtip and msip lines.
module clint_timer
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          TICK_DIV    = 1,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_write,
    input  logic        bus_valid,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        mtip,
    output logic        msip
);
    clint_state_t state;
    logic [3:0]   cnt;
    logic         skip;
    logic         cap_write;
    logic [31:0]  cap_wdata;
    logic [4:0]   cap_sel;
    logic [4:0]   sel;
    logic [31:0]  rd;
    logic [63:0]  mtime;
    logic [63:0]  mtimecmp;
    logic         msip_reg;
    logic         commit;
    logic         unused_ok;

    assign unused_ok = &{1'b0, bus_addr[1:0]};
    assign sel = (bus_addr[31:16] == BASE_ADDR[31:16]) ? clint_decode(bus_addr[15:2]) : '0;
    assign rd = sel[0] ? {31'b0, msip_reg} :
                sel[1] ? mtimecmp[31:0] :
                sel[2] ? mtimecmp[63:32] :
                sel[3] ? mtime[31:0] :
                sel[4] ? mtime[63:32] : '0;
    assign commit = state == ST_RESP && cap_write;
    assign bus_ready = state == ST_RESP;
    assign msip = msip_reg;

    clint_mtime_counter #(.TICK_DIV(TICK_DIV)) u_counter (
        .clk   (clk),
        .rst   (rst),
        .wr_lo (commit && cap_sel[3]),
        .wr_hi (commit && cap_sel[4]),
        .wdata (cap_wdata),
        .mtime (mtime)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            skip      <= 1'b0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
            cap_sel   <= '0;
            bus_rdata <= '0;
            mtimecmp  <= MTIMECMP_RST;
            msip_reg  <= 1'b0;
            mtip      <= 1'b0;
        end else begin
            mtip <= mtime >= mtimecmp;
            case (state)
                ST_IDLE: begin
                    skip <= 1'b0;
                    if (bus_valid && !skip) begin
                        cap_sel   <= sel;
                        cap_write <= bus_write;
                        cap_wdata <= bus_wdata;
                        bus_rdata <= bus_write ? '0 : rd;
                        cnt       <= 4'(WAIT_CYCLES - 1);
                        state     <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    cnt   <= cnt - 4'd1;
                    state <= (cnt == 4'd0) ? ST_RESP : ST_WAIT;
                end
                ST_RESP: begin
                    // The held valid is still high for one cycle; skip blocks a second accept.
                    state     <= ST_IDLE;
                    skip      <= 1'b1;
                    bus_rdata <= '0;
                    if (cap_write && cap_sel[0]) msip_reg <= cap_wdata[0];
                    if (cap_write && cap_sel[1]) mtimecmp[31:0] <= cap_wdata;
                    if (cap_write && cap_sel[2]) mtimecmp[63:32] <= cap_wdata;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: directed and random bus traffic on two CLINT configurations against an arithmetic mtime model.
module tb_clint_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] addr[2], wdata[2], rdata[2];
    logic        wr[2], valid[2], ready[2], mtip[2], msip[2];

    clint_timer #(.TICK_DIV(1), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus_addr(addr[0]), .bus_wdata(wdata[0]), .bus_write(wr[0]),
        .bus_valid(valid[0]), .bus_rdata(rdata[0]), .bus_ready(ready[0]), .mtip(mtip[0]), .msip(msip[0]));
    clint_timer #(.TICK_DIV(3), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .bus_addr(addr[1]), .bus_wdata(wdata[1]), .bus_write(wr[1]),
        .bus_valid(valid[1]), .bus_rdata(rdata[1]), .bus_ready(ready[1]), .mtip(mtip[1]), .msip(msip[1]));

    longint dv[2] = '{1, 3};
    int     wv[2] = '{0, 3};

    // mtime after edge n = anchor value + ticks counted in edges (anc_e, n].
    logic [63:0] anc_val[2];
    longint      anc_e[2];
    logic [63:0] cmp_m[2];
    logic        msip_m[2];
    longint      edge_n = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) edge_n <= rst ? 0 : edge_n + 1;

    function automatic logic [63:0] mt_at(input int k, input longint n);
        return anc_val[k] + 64'(n / dv[k] - anc_e[k] / dv[k]);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            anc_val[k] = '0;
            anc_e[k]   = 0;
            cmp_m[k]   = '1;
            msip_m[k]  = 1'b0;
        end
    endfunction

    function automatic logic [31:0] exp_read(input int k, input logic [31:0] a, input longint n);
        logic [63:0] t;
        t = mt_at(k, n);
        if (a[31:16] != 16'h8000) return '0;
        case ({a[15:2], 2'b00})
            16'h0000: return {31'b0, msip_m[k]};
            16'h4000: return cmp_m[k][31:0];
            16'h4004: return cmp_m[k][63:32];
            16'hBFF8: return t[31:0];
            16'hBFFC: return t[63:32];
            default:  return '0;
        endcase
    endfunction

    function automatic void apply_write(input int k, input logic [31:0] a, input logic [31:0] d, input longint e);
        logic [63:0] v;
        v = mt_at(k, e - 1);
        if (a[31:16] != 16'h8000) return;
        case ({a[15:2], 2'b00})
            16'h0000: msip_m[k] = d[0];
            16'h4000: cmp_m[k][31:0] = d;
            16'h4004: cmp_m[k][63:32] = d;
            16'hBFF8: begin v[31:0] = d; anc_val[k] = v; anc_e[k] = e; end
            16'hBFFC: begin v[63:32] = d; anc_val[k] = v; anc_e[k] = e; end
            default: ;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_irq(input int k);
        chk("msip", {63'b0, msip[k]}, {63'b0, msip_m[k]});
        chk("mtip", {63'b0, mtip[k]}, {63'b0, mt_at(k, edge_n - 1) >= cmp_m[k]});
    endtask

    task automatic xfer(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
        int     lat;
        bit     ok;
        longint acc;
        addr[k] = a; wdata[k] = d; wr[k] = w; valid[k] = 1'b1;
        lat = 0; ok = 0; acc = edge_n + 1;
        while (lat < 40 && !ok) begin
            tick();
            lat++;
            ok = ready[k];
        end
        rd = rdata[k];
        valid[k] = 1'b0;
        chk("latency", 64'(lat), 64'(1 + wv[k]));
        if (ok) begin
            if (!w) chk("rdata", {32'b0, rd}, {32'b0, exp_read(k, a, acc - 1)});
            else apply_write(k, a, d, edge_n + 1);
            tick();
            chk("ready_pulse", {63'b0, ready[k]}, 64'd0);
            tick();
            check_irq(k);
        end
    endtask

    logic [31:0] amap[7] = '{32'h8000_0000, 32'h8000_4000, 32'h8000_4004, 32'h8000_BFF8,
                             32'h8000_BFFC, 32'h8000_1234, 32'hC000_4000};
    logic [31:0] r;

    initial begin
        for (int k = 0; k < 2; k++) begin
            addr[k] = '0; wdata[k] = '0; wr[k] = 1'b0; valid[k] = 1'b0;
        end
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", {63'b0, ready[k]}, 64'd0);
            chk("rst_rdata", {32'b0, rdata[k]}, 64'd0);
            chk("rst_mtip", {63'b0, mtip[k]}, 64'd0);
            chk("rst_msip", {63'b0, msip[k]}, 64'd0);
        end
        xfer(0, 0, 32'h8000_4004, 0, r);
        chk("cmp_hi_rst", {32'b0, r}, 64'hFFFF_FFFF);

        xfer(0, 1, 32'h8000_BFF8, 0, r);
        xfer(0, 1, 32'h8000_BFFC, 0, r);
        xfer(0, 1, 32'h8000_4000, 20, r);
        xfer(0, 1, 32'h8000_4004, 0, r);
        repeat (30) begin
            tick();
            check_irq(0);
        end
        chk("mtip_set", {63'b0, mtip[0]}, 64'd1);
        xfer(0, 1, 32'h8000_4004, 1, r);
        chk("mtip_clr", {63'b0, mtip[0]}, 64'd0);

        xfer(0, 1, 32'h8000_BFFC, 0, r);
        xfer(0, 1, 32'h8000_BFF8, 32'hFFFF_FFFF, r);
        xfer(0, 0, 32'h8000_BFF8, 0, r);
        xfer(0, 0, 32'h8000_BFFC, 0, r);
        chk("carry_hi", {32'b0, r}, 64'd1);
        xfer(0, 1, 32'h8000_BFF8, 32'h100, r);
        xfer(0, 0, 32'h8000_BFF8, 0, r);

        xfer(0, 1, 32'h8000_0000, 1, r);
        chk("msip_on", {63'b0, msip[0]}, 64'd1);
        xfer(0, 0, 32'h8000_0000, 0, r);
        chk("msip_rd", {32'b0, r}, 64'd1);
        xfer(0, 1, 32'h8000_0000, 0, r);

        xfer(0, 1, 32'h8000_1234, 32'hDEAD_BEEF, r);
        xfer(0, 0, 32'h8000_1234, 0, r);
        xfer(1, 1, 32'hC000_0000, 32'h1234_5678, r);
        xfer(1, 0, 32'hC000_0000, 0, r);
        chk("mismatch_rd", {32'b0, r}, 64'd0);
        xfer(1, 0, 32'h8000_4000, 0, r);

        for (int i = 0; i < 60; i++) begin
            int k;
            k = int'($urandom_range(1, 0));
            repeat ($urandom_range(3, 0)) tick();
            xfer(k, 1'($urandom_range(1, 0)), amap[$urandom_range(6, 0)] | 32'($urandom_range(3, 0)),
                 $urandom, r);
        end

        addr[1] = 32'h8000_4000; wdata[1] = 32'h55; wr[1] = 1'b1; valid[1] = 1'b1;
        tick();
        tick();
        chk("wait_no_ready", {63'b0, ready[1]}, 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        valid[1] = 1'b0;
        model_reset();
        repeat (6) begin
            tick();
            chk("abort_no_ready", {63'b0, ready[1]}, 64'd0);
        end
        xfer(1, 0, 32'h8000_4000, 0, r);
        chk("abort_no_commit", {32'b0, r}, 64'hFFFF_FFFF);
        xfer(0, 0, 32'h8000_BFF8, 0, r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
